ch_count_bank: RTL and testbench
================================

// Module: ch_count_bank
// PURPOSE
//  Bank of NUM_CH independent WIDTH-bit up/down counters for the sorting engine's
//  per-key/per-bin occupancy counts (counting-sort histogram). One registered
//  update request per cycle, selectable wrap or saturate mode, sticky per-channel
//  overflow flags, synchronous clear-all and a registered read port.
//  Successor to the fixed 15-bit ripple incrementer: generalised width, channel
//  count and direction, with state.
// PARAMETERS
//  WIDTH    15  counter width in bits (>=2)
//  NUM_CH   8   number of counters (>=2)
//  CH_W     3   channel index width, = $clog2(NUM_CH)
//  SATURATE 1   1: clamp at max/0 on overflow/underflow; 0: wrap modulo 2^WIDTH
// PORTS
//  CLK      in   1         clock, all state updates on rising edge
//  RSTn     in   1         asynchronous active-low reset
//  UPD      in   1         update request valid (accepted every cycle, no backpressure)
//  UPD_CH   in   CH_W      channel to update; values >= NUM_CH are ignored
//  UPD_DN   in   1         0: +1, 1: -1
//  CLR      in   1         synchronous clear of all counters, flags and pending request
//  RD_CH    in   CH_W      read channel select
//  RD_DATA  out  WIDTH     counter[RD_CH], registered
//  OVF      out  NUM_CH    sticky per-channel overflow/underflow flags
//  BUSY     out  1         update pipeline holds an uncommitted request
// BEHAVIOUR
//  Reset (RSTn=0, async): all counters 0, OVF=0, RD_DATA=0, BUSY=0, pipeline empty.
//  Pipeline: S1 registers {UPD,UPD_CH,UPD_DN}; S2 (next edge) commits to counter.
//   Request at edge N is visible in the counter after edge N+1; BUSY = S1 valid.
//  Back-to-back requests to the same channel: each applies exactly once, in order.
//   The S2 adder always uses the current counter value, so no update is lost.
//  Arithmetic: next = cnt +/- 1 through the inc_dec_n sub-module (carry/borrow out).
//   Up at all-ones: SATURATE=1 -> hold 2^WIDTH-1; SATURATE=0 -> 0. OVF[ch] set in both modes.
//   Down at 0: SATURATE=1 -> hold 0; SATURATE=0 -> all-ones. OVF[ch] set in both modes.
//   OVF bits stay set until CLR or reset.
//  Out-of-range UPD_CH (>= NUM_CH): request dropped in S1, no state change, BUSY stays 0.
//  CLR has priority: at a CLR edge, counters and OVF go to 0 and any S1 request is
//   discarded. A UPD presented in the same cycle as CLR is also discarded.
//  RD_DATA: 1-cycle latency; at each edge RD_DATA <= counter[RD_CH] as it stood
//   before that edge. A commit on that same edge shows one cycle later.
//   RD_CH >= NUM_CH gives RD_DATA=0. During CLR, RD_DATA <= 0.
//  No combinational path from any input to any output.
// STRUCTURE
//  Package ch_count_pkg: mode localparams (MODE_WRAP=0, MODE_SAT=1), the default
//   WIDTH/NUM_CH and the derived CH_W function, shared with the sorter control.
//  Sub-module inc_dec_n #(WIDTH): combinational A +/- 1 with DN select, Sum and CO
//   (carry or borrow). Generalises the existing incrementer; one instance in S2.
//  Counters are a flop array, not RAM, for single-cycle read-modify-write.
// TESTING
//  1) Reset, then UPD ch2 up x5 on consecutive cycles -> counter[2]=5 two cycles
//     after the last request; BUSY high throughout; other channels 0.
//  2) WIDTH=4, SATURATE=1: 17 ups on ch0 -> counter[0]=15, OVF[0]=1.
//     Then 1 down -> 14, and OVF[0] stays 1.
//  3) WIDTH=4, SATURATE=0: 16 ups on ch1 -> counter[1]=0, OVF[1]=1.
//     Down on ch3 from 0 -> 15, OVF[3]=1.
//  4) CLR asserted while S1 holds ch4 up and UPD ch4 is presented -> counter[4]=0,
//     OVF=0, BUSY=0 next cycle, no later increment appears.
//  5) RD_CH=2 held while ch2 commits 6->7 -> RD_DATA shows 6, then 7 one cycle later.
//     RD_CH=NUM_CH -> 0.
//  6) Interleaved ups to ch1/ch5, UPD_CH=NUM_CH+1 injected, RSTn pulsed mid-stream
//     -> ignored request changes nothing; async reset zeros all outputs immediately.

Source files
------------

// File: rtl/ch_count_pkg.sv
// rtl/ch_count_pkg.sv - shared constants and types for the channel counter bank
// Purpose: mode selectors, default geometry and channel-index width helper,
//          shared between the counter bank and the sorter control.
// Ports:   none (package)
package ch_count_pkg;

  localparam int MODE_WRAP  = 0;
  localparam int MODE_SAT   = 1;

  localparam int DEF_WIDTH  = 15;
  localparam int DEF_NUM_CH = 8;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

  // Index width for n channels; never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/inc_dec_n.sv
// rtl/inc_dec_n.sv - combinational WIDTH-bit increment/decrement by one
// Purpose: sum = a + 1 (dn=0) or a - 1 (dn=1), co = carry out on up, borrow on down.
// Ports:   a   in  WIDTH  operand
//          dn  in  1      0: increment, 1: decrement
//          sum out WIDTH  result modulo 2^WIDTH
//          co  out 1      carry (up at all-ones) or borrow (down at zero)
module inc_dec_n #(
  parameter int WIDTH = 15
) (
  input  logic [WIDTH-1:0] a,
  input  logic             dn,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

  logic [WIDTH:0] ext;
  logic [WIDTH:0] res;

  // One extra bit catches the carry on increment and, through wrap of the
  // extended value, the borrow on decrement from zero.
  assign ext       = {1'b0, a};
  assign res       = dn ? (ext - ONE) : (ext + ONE);
  assign {co, sum} = res;

endmodule

// File: rtl/ch_count_bank.sv
// rtl/ch_count_bank.sv - bank of per-channel up/down occupancy counters
// Purpose: NUM_CH WIDTH-bit counters updated through a two-stage pipeline
//          (S1 request register, S2 read-modify-write commit), wrap or saturate
//          mode, sticky per-channel overflow flags, sync clear, registered read.
// Ports:   CLK      in  1       clock
//          RSTn     in  1       asynchronous active-low reset
//          UPD      in  1       update request valid
//          UPD_CH   in  CH_W    channel to update (>= NUM_CH ignored)
//          UPD_DN   in  1       0: +1, 1: -1
//          CLR      in  1       synchronous clear of counters, flags, pending request
//          RD_CH    in  CH_W    read channel select
//          RD_DATA  out WIDTH   counter[RD_CH], one cycle latency
//          OVF      out NUM_CH  sticky overflow/underflow flags
//          BUSY     out 1       S1 holds an uncommitted request
module ch_count_bank
  import ch_count_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int CH_W     = ch_w(NUM_CH),
  parameter int SATURATE = MODE_SAT
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              UPD,
  input  logic [CH_W-1:0]   UPD_CH,
  input  logic              UPD_DN,
  input  logic              CLR,
  input  logic [CH_W-1:0]   RD_CH,
  output logic [WIDTH-1:0]  RD_DATA,
  output logic [NUM_CH-1:0] OVF,
  output logic              BUSY
);

  localparam logic [CH_W:0] CH_LIMIT = (CH_W+1)'(NUM_CH);
  localparam bit            SAT_EN   = (SATURATE == MODE_SAT);

  logic [WIDTH-1:0]  cnt [NUM_CH];
  logic [NUM_CH-1:0] ovf;
  logic [WIDTH-1:0]  rd_data;

  logic              s1_vld;
  logic [CH_W-1:0]   s1_ch;
  dir_e              s1_dn;

  logic              upd_ok;
  logic [WIDTH-1:0]  cur;
  logic [WIDTH-1:0]  rd_sel;
  logic [WIDTH-1:0]  sum;
  logic              co;
  logic [WIDTH-1:0]  nxt;

  assign upd_ok = UPD && ({1'b0, UPD_CH} < CH_LIMIT);

  // Channel muxes; an index with no matching channel reads as zero.
  always_comb begin
    cur    = '0;
    rd_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (s1_ch == CH_W'(i)) cur    = cnt[i];
      if (RD_CH == CH_W'(i)) rd_sel = cnt[i];
    end
  end

  inc_dec_n #(.WIDTH(WIDTH)) u_inc_dec (
    .a   (cur),
    .dn  (s1_dn == DIR_DN),
    .sum (sum),
    .co  (co)
  );

  // On carry/borrow, saturating mode keeps the current value (already at the rail).
  assign nxt = (co && SAT_EN) ? cur : sum;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      ovf     <= '0;
      rd_data <= '0;
      s1_vld  <= 1'b0;
      s1_ch   <= '0;
      s1_dn   <= DIR_UP;
    end else if (CLR) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      ovf     <= '0;
      rd_data <= '0;
      s1_vld  <= 1'b0;
    end else begin
      s1_vld  <= upd_ok;
      s1_ch   <= UPD_CH;
      s1_dn   <= dir_e'(UPD_DN);
      // Read samples the pre-edge counter value, so a same-edge commit shows next cycle.
      rd_data <= rd_sel;
      for (int i = 0; i < NUM_CH; i++) begin
        if (s1_vld && (s1_ch == CH_W'(i))) begin
          cnt[i] <= nxt;
          if (co) ovf[i] <= 1'b1;
        end
      end
    end
  end

  assign RD_DATA = rd_data;
  assign OVF     = ovf;
  assign BUSY    = s1_vld;

endmodule

// File: tb/tb_ch_count_bank.sv
// tb/tb_ch_count_bank.sv - directed self-checking bench for ch_count_bank
// Purpose: drives one saturating and one wrapping 4-bit, 6-channel bank with the
//          same stimulus and compares against hand-computed expectations.
// Ports:   none (top-level bench)
module tb_ch_count_bank;

  localparam int W  = 4;
  localparam int NC = 6;
  localparam int CW = 3;

  logic          CLK;
  logic          RSTn;
  logic          UPD;
  logic [CW-1:0] UPD_CH;
  logic          UPD_DN;
  logic          CLR;
  logic [CW-1:0] RD_CH;

  logic [W-1:0]  rd_sat,   rd_wrap;
  logic [NC-1:0] ovf_sat,  ovf_wrap;
  logic          busy_sat, busy_wrap;

  int total;
  int bad;

  ch_count_bank #(.WIDTH(W), .NUM_CH(NC), .CH_W(CW), .SATURATE(1)) u_sat (
    .CLK(CLK), .RSTn(RSTn), .UPD(UPD), .UPD_CH(UPD_CH), .UPD_DN(UPD_DN),
    .CLR(CLR), .RD_CH(RD_CH), .RD_DATA(rd_sat), .OVF(ovf_sat), .BUSY(busy_sat)
  );

  ch_count_bank #(.WIDTH(W), .NUM_CH(NC), .CH_W(CW), .SATURATE(0)) u_wrap (
    .CLK(CLK), .RSTn(RSTn), .UPD(UPD), .UPD_CH(UPD_CH), .UPD_DN(UPD_DN),
    .CLR(CLR), .RD_CH(RD_CH), .RD_DATA(rd_wrap), .OVF(ovf_wrap), .BUSY(busy_wrap)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    total++;
    if (obs !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // n consecutive requests, then one idle cycle so the last one commits.
  task automatic send(input int ch, input bit dn, input int n);
    for (int i = 0; i < n; i++) begin
      UPD    = 1'b1;
      UPD_CH = CW'(ch);
      UPD_DN = dn;
      tick();
    end
    UPD = 1'b0;
    tick();
  endtask

  task automatic read_ch(input int ch);
    UPD   = 1'b0;
    RD_CH = CW'(ch);
    tick();
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    RSTn   = 1'b0;
    UPD    = 1'b0;
    UPD_CH = '0;
    UPD_DN = 1'b0;
    CLR    = 1'b0;
    RD_CH  = '0;

    #12;
    check("rst_rd_sat",    rd_sat,    0);
    check("rst_rd_wrap",   rd_wrap,   0);
    check("rst_ovf_sat",   ovf_sat,   0);
    check("rst_busy_sat",  busy_sat,  0);
    RSTn = 1'b1;
    tick();

    // five back-to-back ups on ch2
    for (int i = 0; i < 5; i++) begin
      UPD = 1'b1; UPD_CH = 3'd2; UPD_DN = 1'b0;
      tick();
      check("t1_busy", busy_sat, 1);
    end
    UPD = 1'b0;
    tick();
    check("t1_busy_idle", busy_sat, 0);
    read_ch(2);
    check("t1_ch2_sat",  rd_sat,  5);
    check("t1_ch2_wrap", rd_wrap, 5);
    read_ch(0);
    check("t1_ch0", rd_sat, 0);
    read_ch(5);
    check("t1_ch5", rd_wrap, 0);

    // overflow at the top rail
    send(0, 1'b0, 17);
    read_ch(0);
    check("t2_ch0_sat",      rd_sat,      15);
    check("t2_ch0_wrap",     rd_wrap,     1);
    check("t2_ovf0_sat",     ovf_sat[0],  1);
    check("t2_ovf0_wrap",    ovf_wrap[0], 1);
    send(0, 1'b1, 1);
    read_ch(0);
    check("t2_dn_sat",       rd_sat,      14);
    check("t2_dn_wrap",      rd_wrap,     0);
    check("t2_ovf0_sticky",  ovf_sat[0],  1);
    send(1, 1'b0, 16);
    read_ch(1);
    check("t3_ch1_sat",      rd_sat,      15);
    check("t3_ch1_wrap",     rd_wrap,     0);
    // underflow at zero
    send(3, 1'b1, 1);
    read_ch(3);
    check("t3_ch3_sat",      rd_sat,      0);
    check("t3_ch3_wrap",     rd_wrap,     15);
    check("t3_ovf_sat",      ovf_sat,     6'b001011);
    check("t3_ovf_wrap",     ovf_wrap,    6'b001011);

    // clear with a request in S1 and another presented
    send(4, 1'b0, 2);
    RD_CH = 3'd0;
    UPD = 1'b1; UPD_CH = 3'd4; UPD_DN = 1'b0;
    tick();
    check("t4_busy_pre", busy_sat, 1);
    check("t4_rd_pre",   rd_sat,   14);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    UPD = 1'b0;
    check("t4_busy",     busy_sat, 0);
    check("t4_ovf_sat",  ovf_sat,  0);
    check("t4_ovf_wrap", ovf_wrap, 0);
    check("t4_rd_clr",   rd_sat,   0);
    tick();
    tick();
    read_ch(4);
    check("t4_ch4_sat",  rd_sat,  0);
    check("t4_ch4_wrap", rd_wrap, 0);

    // read timing around a commit
    send(2, 1'b0, 6);
    RD_CH = 3'd2;
    UPD = 1'b1; UPD_CH = 3'd2; UPD_DN = 1'b0;
    tick();
    check("t5_rd_before", rd_sat, 6);
    UPD = 1'b0;
    tick();
    check("t5_rd_commit_edge", rd_sat, 6);
    tick();
    check("t5_rd_after",  rd_sat,  7);
    check("t5_rd_wrap",   rd_wrap, 7);
    read_ch(NC);
    check("t5_rd_oob", rd_sat, 0);

    // interleaved traffic, out-of-range channel, async reset mid-stream
    RSTn = 1'b0;
    #2;
    RSTn = 1'b1;
    tick();
    UPD = 1'b1; UPD_DN = 1'b0;
    UPD_CH = 3'd1; tick();
    UPD_CH = 3'd5; tick();
    UPD_CH = 3'd7; tick();
    check("t6_busy_oob", busy_sat, 0);
    UPD_CH = 3'd1; tick();
    UPD = 1'b0;
    tick();
    read_ch(1);
    check("t6_ch1", rd_sat, 2);
    read_ch(5);
    check("t6_ch5", rd_wrap, 1);
    check("t6_ovf", ovf_sat, 0);
    send(3, 1'b1, 1);
    check("t6_ovf3", ovf_wrap, 6'b001000);
    RD_CH = 3'd1;
    UPD = 1'b1; UPD_CH = 3'd1; UPD_DN = 1'b0;
    tick();
    check("t6_busy_pre", busy_sat, 1);
    check("t6_rd_pre",   rd_sat,   2);
    #2;
    RSTn = 1'b0;
    #1;
    check("t6_async_rd",   rd_sat,    0);
    check("t6_async_busy", busy_wrap, 0);
    check("t6_async_ovf",  ovf_wrap,  0);
    UPD = 1'b0;
    #1;
    RSTn = 1'b1;
    tick();
    read_ch(1);
    check("t6_ch1_after_rst", rd_sat, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
